// File: rtl/mult_feeder_if.sv
// mult_feeder_if: operand, multiplier and product handshakes.
// slave = feeder side, master = surrounding system.
interface mult_feeder_if #(
  parameter int WIDTH = 7
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic               mult_start;
  logic [WIDTH-1:0]   mult_a;
  logic [WIDTH-1:0]   mult_b;
  logic [2*WIDTH-1:0] mult_result;
  logic               mult_done;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_result;
  logic [3:0]         out_tag;

  modport slave (
    input  in_valid, in_a, in_b,
    input  mult_result, mult_done,
    input  out_ready,
    output in_ready,
    output mult_start, mult_a, mult_b,
    output out_valid, out_result, out_tag
  );

  modport master (
    output in_valid, in_a, in_b,
    output mult_result, mult_done,
    output out_ready,
    input  in_ready,
    input  mult_start, mult_a, mult_b,
    input  out_valid, out_result, out_tag
  );
endinterface

// File: rtl/mult_feeder.sv
// mult_feeder: FIFO-buffered, one-at-a-time launcher for a multiplier.
// Define MULT_FEEDER_TIMEOUT_EN to add the WAIT watchdog and err output.
module mult_feeder #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 4
`ifdef MULT_FEEDER_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 32
`endif
) (
  input  logic         clock,
  input  logic         reset,
  mult_feeder_if.slave bus,
  output logic         busy
`ifdef MULT_FEEDER_TIMEOUT_EN
  ,
  output logic         err
`endif
);
  localparam int PW = 2 * WIDTH;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_ARM,
    S_WAIT
  } state_t;

  state_t state, nxt;

  logic [PW-1:0]    mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [CW-1:0]    count;
  logic             wr, pop, cap, abort;
  logic [WIDTH-1:0] a_q, b_q;
  logic [PW-1:0]    res_q;
  logic             vld_q;
  logic [3:0]       tag_q, seq_q;

  assign bus.in_ready   = (count != CW'(DEPTH));
  assign wr             = bus.in_valid && bus.in_ready;
  assign bus.mult_start = (state == S_ISSUE);
  assign bus.mult_a     = a_q;
  assign bus.mult_b     = b_q;
  assign bus.out_valid  = vld_q;
  assign bus.out_result = res_q;
  assign bus.out_tag    = tag_q;
  assign busy = (state != S_IDLE) || (count != '0);

  always_ff @(posedge clock) begin
    if (wr) mem[wptr] <= {bus.in_a, bus.in_b};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr)  wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      unique case ({wr, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef MULT_FEEDER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wcnt;
  logic          err_q;

  assign abort = (state == S_WAIT) && !bus.mult_done
              && (wcnt == TW'(TIMEOUT - 1));
  assign err   = err_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wcnt  <= '0;
      err_q <= 1'b0;
    end else begin
      if (state != S_WAIT) wcnt <= '0;
      else                 wcnt <= wcnt + 1'b1;
      if (abort) err_q <= 1'b1;
    end
  end
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= nxt;
  end

  // ARM never looks at mult_done: it may still be high from the last op
  always_comb begin
    nxt = state;
    pop = 1'b0;
    cap = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (count != '0 && !vld_q) begin
          pop = 1'b1;
          nxt = S_ISSUE;
        end
      end
      S_ISSUE: nxt = S_ARM;
      S_ARM:   nxt = S_WAIT;
      S_WAIT: begin
        if (bus.mult_done || abort) begin
          cap = 1'b1;
          nxt = S_IDLE;
        end
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      vld_q <= 1'b0;
      tag_q <= '0;
      seq_q <= '0;
    end else begin
      if (pop) {a_q, b_q} <= mem[rptr];
      if (cap) begin
        // an aborted multiply reports an all-ones product
        res_q <= bus.mult_done ? bus.mult_result : '1;
        tag_q <= seq_q;
        seq_q <= seq_q + 1'b1;
        vld_q <= 1'b1;
      end else if (vld_q && bus.out_ready) begin
        vld_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mult_feeder.sv
// tb_mult_feeder: randomized bench with a behavioural multiplier
// and an arithmetic scoreboard of expected products and tags.
module tb_mult_feeder;
  localparam int W  = 7;
  localparam int PW = 2 * W;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
`ifdef MULT_FEEDER_TIMEOUT_EN
  logic err;
`endif

  always #5 clock = ~clock;

  mult_feeder_if #(.WIDTH(W)) bus ();

  mult_feeder #(
    .WIDTH(W),
    .DEPTH(4)
  ) dut (
    .clock(clock),
    .reset(rst_n),
    .bus  (bus),
    .busy (busy)
`ifdef MULT_FEEDER_TIMEOUT_EN
    ,
    .err  (err)
`endif
  );

  int checks = 0;
  int errors = 0;

  int lat   = 8;
  bit stale = 1'b0;
  bit never = 1'b0;

  int cnt = 0;
  bit stale_pend = 1'b0;
  logic [W-1:0] ma = '0, mb = '0;
  int starts = 0, start_bad = 0, stab_bad = 0, hold_bad = 0;

  // Ideal multiplier: done is a level held until the next start.
  always @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      bus.mult_done   <= 1'b0;
      bus.mult_result <= '0;
      cnt        <= 0;
      stale_pend <= 1'b0;
    end else if (bus.mult_start) begin
      ma  <= bus.mult_a;
      mb  <= bus.mult_b;
      cnt <= lat;
      starts = starts + 1;
      if (bus.out_valid) start_bad = start_bad + 1;
      if (stale) stale_pend <= 1'b1;
      else       bus.mult_done <= 1'b0;
    end else begin
      if (cnt > 0 && (bus.mult_a !== ma || bus.mult_b !== mb))
        stab_bad = stab_bad + 1;
      if (stale_pend) begin
        bus.mult_done <= 1'b0;
        stale_pend    <= 1'b0;
      end
      if (cnt > 0) begin
        cnt <= cnt - 1;
        if (cnt == 1 && !never) begin
          bus.mult_done   <= 1'b1;
          bus.mult_result <= PW'(ma) * PW'(mb);
        end
      end
    end
  end

  logic [PW-1:0] got_res [256];
  logic [3:0]    got_tag [256];
  int n_got  = 0;
  int rd_got = 0;
  bit hold_chk = 1'b0;
  logic [PW-1:0] hr;
  logic [3:0]    ht;

  always @(posedge clock) begin
    hold_chk = rst_n && bus.out_valid && !bus.out_ready;
    hr = bus.out_result;
    ht = bus.out_tag;
    if (rst_n && bus.out_valid && bus.out_ready && n_got < 256) begin
      got_res[n_got] = bus.out_result;
      got_tag[n_got] = bus.out_tag;
      n_got = n_got + 1;
    end
  end

  always @(negedge clock) begin
    if (hold_chk && rst_n &&
        (!bus.out_valid || bus.out_result !== hr || bus.out_tag !== ht))
      hold_bad = hold_bad + 1;
  end

  logic [PW-1:0] exp_res [$];
  logic [3:0]    exp_tag = '0;

  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
    int t = 0;
    @(negedge clock);
    bus.in_valid = 1'b1;
    bus.in_a = a;
    bus.in_b = b;
    while (!bus.in_ready && t < 300) begin
      @(negedge clock);
      t++;
    end
    if (bus.in_ready) begin
      exp_res.push_back(PW'(a) * PW'(b));
      @(posedge clock);
    end else begin
      checks++;
      errors++;
      $display("FAIL push_timeout a=%0d b=%0d in_ready stuck 0", a, b);
    end
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int n, output bit ok);
    int t = 0;
    while ((n_got - rd_got) < n && t < 3000) begin
      @(negedge clock);
      t++;
    end
    ok = (n_got - rd_got) >= n;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.mult_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got v=%b s=%b exp 0 0",
               bus.out_valid, bus.mult_start);
    end
    checks++;
    if (bus.mult_a !== '0 || bus.mult_b !== '0) begin
      errors++;
      $display("FAIL reset_operands got %0d %0d exp 0 0",
               bus.mult_a, bus.mult_b);
    end
    checks++;
    if (bus.out_result !== '0 || bus.out_tag !== '0) begin
      errors++;
      $display("FAIL reset_output got %0d tag %0d exp 0 tag 0",
               bus.out_result, bus.out_tag);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got %b exp 0", busy);
    end
    rst_n = 1'b1;
    @(negedge clock);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b exp 1", bus.in_ready);
    end
  endtask

  task automatic test_single;
    int s0 = starts;
    int b0 = stab_bad;
    int n = 0;
    bit ok;
    lat = 8;
    bus.out_ready = 1'b1;
    push(7'd5, 7'd9);
    while (!bus.out_valid && n < 200) begin
      @(posedge clock);
      #1 n++;
    end
    // pop, ISSUE, start seen, lat cycles to done, capture
    checks++;
    if (n != lat + 3) begin
      errors++;
      $display("FAIL single_latency got %0d exp %0d", n, lat + 3);
    end
    wait_drain(1, ok);
    checks++;
    if (!ok || got_res[rd_got] !== 14'd45 || got_tag[rd_got] !== 4'd0) begin
      errors++;
      $display("FAIL single_result got %0d tag %0d exp 45 tag 0",
               got_res[rd_got], got_tag[rd_got]);
    end
    rd_got++;
    void'(exp_res.pop_front());
    exp_tag++;
    checks++;
    if (starts - s0 != 1 || stab_bad != b0) begin
      errors++;
      $display("FAIL single_start got starts=%0d unstable=%0d exp 1 0",
               starts - s0, stab_bad - b0);
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] ta [4] = '{7'd127, 7'd0, 7'd1, 7'd64};
    logic [W-1:0] tb [4] = '{7'd127, 7'd33, 7'd1, 7'd2};
    int sb0 = start_bad;
    bit ok;
    lat = $urandom_range(3, 9);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) push(ta[i], tb[i]);
    wait_drain(4, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL b2b_drain got %0d exp 4", n_got - rd_got);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got_res[rd_got] !== exp_res[0] || got_tag[rd_got] !== exp_tag) begin
        errors++;
        $display("FAIL b2b_result[%0d] got %0d tag %0d exp %0d tag %0d",
                 i, got_res[rd_got], got_tag[rd_got], exp_res[0], exp_tag);
      end
      rd_got++;
      void'(exp_res.pop_front());
      exp_tag++;
    end
    checks++;
    if (start_bad != sb0) begin
      errors++;
      $display("FAIL b2b_start_while_valid got %0d exp 0", start_bad - sb0);
    end
  endtask

  task automatic test_random;
    bit pd = 1'b0;
    bit ok;
    int h0 = hold_bad;
    int b0 = stab_bad;
    lat = $urandom_range(2, 12);
    fork
      begin
        for (int i = 0; i < 20; i++)
          push(W'($urandom), W'($urandom));
        pd = 1'b1;
      end
      begin
        while (!pd) begin
          @(negedge clock);
          bus.out_ready = 1'($urandom_range(0, 1));
        end
        bus.out_ready = 1'b1;
      end
    join
    wait_drain(20, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rand_drain got %0d exp 20", n_got - rd_got);
    end
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (got_res[rd_got] !== exp_res[0] || got_tag[rd_got] !== exp_tag) begin
        errors++;
        $display("FAIL rand_result[%0d] got %0d tag %0d exp %0d tag %0d",
                 i, got_res[rd_got], got_tag[rd_got], exp_res[0], exp_tag);
      end
      rd_got++;
      void'(exp_res.pop_front());
      exp_tag++;
    end
    checks++;
    if (hold_bad != h0 || stab_bad != b0) begin
      errors++;
      $display("FAIL rand_stability got hold=%0d op=%0d exp 0 0",
               hold_bad - h0, stab_bad - b0);
    end
  endtask

  task automatic test_backpressure;
    int i = 0;
    int h0 = hold_bad;
    bit ok;
    lat = 4;
    bus.out_ready = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      bus.in_valid = (i < 6);
      bus.in_a = W'($urandom);
      bus.in_b = W'($urandom);
      if (i < 6 && bus.in_ready) begin
        exp_res.push_back(PW'(bus.in_a) * PW'(bus.in_b));
        i++;
      end
    end
    @(negedge clock);
    bus.in_valid = 1'b0;
    // one pair is drawn into the multiplier, four more fill the FIFO
    checks++;
    if (i != 5 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_accept got %0d ready=%b exp 5 ready=0",
               i, bus.in_ready);
    end
    checks++;
    if (n_got != rd_got || bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_stall got %0d out valid=%b exp 0 valid=1",
               n_got - rd_got, bus.out_valid);
    end
    repeat (5) @(negedge clock);
    bus.out_ready = 1'b1;
    wait_drain(i, ok);
    checks++;
    if (!ok || hold_bad != h0) begin
      errors++;
      $display("FAIL bp_drain got %0d hold=%0d exp %0d hold=0",
               n_got - rd_got, hold_bad - h0, i);
    end
    for (int k = 0; k < i; k++) begin
      checks++;
      if (got_res[rd_got] !== exp_res[0] || got_tag[rd_got] !== exp_tag) begin
        errors++;
        $display("FAIL bp_result[%0d] got %0d tag %0d exp %0d tag %0d",
                 k, got_res[rd_got], got_tag[rd_got], exp_res[0], exp_tag);
      end
      rd_got++;
      void'(exp_res.pop_front());
      exp_tag++;
    end
  endtask

  task automatic test_stale;
    bit ok;
    lat = 6;
    stale = 1'b1;
    bus.out_ready = 1'b1;
    push(7'd3, 7'd4);
    push(7'd10, 7'd11);
    wait_drain(2, ok);
    stale = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (!ok || got_res[rd_got] !== exp_res[0] ||
          got_tag[rd_got] !== exp_tag) begin
        errors++;
        $display("FAIL stale_result[%0d] got %0d tag %0d exp %0d tag %0d",
                 k, got_res[rd_got], got_tag[rd_got], exp_res[0], exp_tag);
      end
      rd_got++;
      void'(exp_res.pop_front());
      exp_tag++;
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    lat = 10;
    bus.out_ready = 1'b1;
    push(7'd7, 7'd7);
    repeat (5) @(negedge clock);
    checks++;
    if (busy !== 1'b1 || bus.mult_a !== 7'd7) begin
      errors++;
      $display("FAIL rmid_inflight got busy=%b a=%0d exp 1 7",
               busy, bus.mult_a);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_result !== '0 || bus.out_tag !== '0 ||
        bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rmid_out got %0d tag %0d v=%b exp 0 0 0",
               bus.out_result, bus.out_tag, bus.out_valid);
    end
    checks++;
    if (bus.mult_a !== '0 || bus.mult_b !== '0 || busy !== 1'b0 ||
        bus.mult_start !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rmid_ctl got a=%0d b=%0d busy=%b exp 0 0 0",
               bus.mult_a, bus.mult_b, busy);
    end
    @(negedge clock);
    rst_n = 1'b1;
    rd_got = n_got;
    exp_res.delete();
    exp_tag = '0;
    push(7'd2, 7'd3);
    wait_drain(1, ok);
    checks++;
    if (!ok || got_res[rd_got] !== 14'd6 || got_tag[rd_got] !== 4'd0) begin
      errors++;
      $display("FAIL rmid_after got %0d tag %0d exp 6 tag 0",
               got_res[rd_got], got_tag[rd_got]);
    end
    rd_got++;
    void'(exp_res.pop_front());
    exp_tag++;
  endtask

`ifdef MULT_FEEDER_TIMEOUT_EN
  task automatic test_timeout;
    bit ok;
    lat = 5;
    never = 1'b1;
    bus.out_ready = 1'b1;
    push(7'd3, 7'd3);
    wait_drain(1, ok);
    never = 1'b0;
    checks++;
    if (!ok || got_res[rd_got] !== 14'h3fff || got_tag[rd_got] !== exp_tag ||
        err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_abort got %0d tag %0d err=%b exp 16383 tag %0d 1",
               got_res[rd_got], got_tag[rd_got], err, exp_tag);
    end
    rd_got++;
    void'(exp_res.pop_front());
    exp_tag++;
    push(7'd2, 7'd2);
    wait_drain(1, ok);
    checks++;
    if (!ok || got_res[rd_got] !== 14'd4 || got_tag[rd_got] !== exp_tag ||
        err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_next got %0d tag %0d err=%b exp 4 tag %0d 1",
               got_res[rd_got], got_tag[rd_got], err, exp_tag);
    end
    rd_got++;
    void'(exp_res.pop_front());
    exp_tag++;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_random();
    test_backpressure();
    test_stale();
    test_reset_mid();
`ifdef MULT_FEEDER_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
